// File: rtl/shared_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : shared_mem_arbiter_if
//  Purpose  : Bundles the fetch port, the load/store port and the RAM-side
//             signals of the shared memory arbiter.
//             The slave modport is the arbiter's view.
//             The master modport is the pipeline/RAM view.
//  Revision : 1.0  initial release
// ============================================================================
interface shared_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // IF-stage fetch port
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_rdata_o;
    logic          if_stall_o;

    // MEM-stage load/store port
    logic          mem_read_i;
    logic          mem_write_i;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_wdata_i;
    logic [DW-1:0] mem_rdata_o;
    logic          mem_stall_o;

    // Fixed-latency single-port RAM
    logic          ram_en_o;
    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_stall_o,
        input  mem_read_i, mem_write_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, mem_stall_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_stall_o,
        output mem_read_i, mem_write_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, mem_stall_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/shared_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : shared_mem_arbiter
//  Purpose  : Shares one single-port fixed-latency RAM between the IF-stage
//             fetch port and the MEM-stage load/store port.
//             The data port wins ties, so the older instruction goes first.
//             Each access runs IDLE -> BUSY (LAT cycles) -> DONE.
//             The requesting port stalls until its DONE cycle.
//  Revision : 1.0  initial release
// ============================================================================
module shared_mem_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2      // RAM read latency, 1..15
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,   // asynchronous, active-low
    shared_mem_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF   = 1'b0,
        OWN_DATA = 1'b1
    } own_t;

    // Loaded on grant. BUSY then lasts exactly LAT cycles, ending at cnt == 0.
    localparam logic [3:0] c_CNT_LOAD = 4'(LAT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    own_t            r_own;
    logic [3:0]      r_cnt;
    logic            r_ram_en;
    logic            r_ram_we;
    logic [AW-1:0]   r_ram_addr;
    logic [DW-1:0]   r_ram_wdata;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_mem_rdata;

    logic            w_mem_req;
    logic            w_start;      // grant a new access this cycle
    logic            w_pick_data;  // the grant goes to the load/store port
    logic            w_finish;     // last BUSY cycle: RAM data is valid now
    logic            w_count;      // BUSY cycle that is not the last one

    // A simultaneous read and write is treated as a write. So any data-port
    // activity counts as a request.
    assign w_mem_req = bus.mem_read_i | bus.mem_write_i;

    // Next-state and per-cycle control decode. Arbitration happens only in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_pick_data = 1'b0;
        w_finish    = 1'b0;
        w_count     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_req) begin
                    w_state_nxt = S_BUSY;
                    w_start     = 1'b1;
                    w_pick_data = 1'b1;
                end else if (bus.if_req_i) begin
                    w_state_nxt = S_BUSY;
                    w_start     = 1'b1;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DONE;
                    w_finish    = 1'b1;
                end else begin
                    w_count     = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register. Reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch owner, address and write data on grant. Hold them for the whole
    // access so later changes on the request ports are ignored.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_own       <= OWN_IF;
            r_cnt       <= 4'd0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else if (w_start) begin
            r_own      <= w_pick_data ? OWN_DATA : OWN_IF;
            r_cnt      <= c_CNT_LOAD;
            r_ram_en   <= 1'b1;
            r_ram_we   <= w_pick_data & bus.mem_write_i;
            r_ram_addr <= w_pick_data ? bus.mem_addr_i : bus.if_addr_i;
            if (w_pick_data) begin
                r_ram_wdata <= bus.mem_wdata_i;
            end
        end else if (w_finish) begin
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
        end else if (w_count) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Capture RAM read data for the owning port. Writes leave both holding
    // registers untouched. A flushed access still updates its register, but
    // the requester has gone and ignores the value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else if (w_finish) begin
            if (r_own == OWN_IF) begin
                r_if_rdata <= bus.ram_rdata_i;
            end else if (!r_ram_we) begin
                r_mem_rdata <= bus.ram_rdata_i;
            end
        end
    end

    // A port stalls while it requests, except during the DONE cycle of its
    // own access. A dropped request therefore never stalls.
    assign bus.if_stall_o  = bus.if_req_i &
                             ~((r_state == S_DONE) && (r_own == OWN_IF));
    assign bus.mem_stall_o = w_mem_req &
                             ~((r_state == S_DONE) && (r_own == OWN_DATA));

    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.mem_rdata_o = r_mem_rdata;
    assign bus.ram_en_o    = r_ram_en;
    assign bus.ram_we_o    = r_ram_we;
    assign bus.ram_addr_o  = r_ram_addr;
    assign bus.ram_wdata_o = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_shared_mem_arbiter
//  Purpose  : Self-checking bench for shared_mem_arbiter.
//             Three instances run with LAT = 2, 1 and 15.
//             One set of stimulus signals is steered to the instance chosen
//             by sel.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shared_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    int          sel;
    int          cur_lat;
    logic        ram_init;

    logic        t_if_req, t_mem_read, t_mem_write;
    logic [31:0] t_if_addr, t_mem_addr, t_mem_wdata;
    logic [31:0] ram_rdata;

    logic        o_if_stall, o_mem_stall, o_ram_en, o_ram_we;
    logic [31:0] o_if_rdata, o_mem_rdata, o_ram_addr, o_ram_wdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shared_mem_arbiter_if #(.AW(AW), .DW(DW)) u_if0 ();
    shared_mem_arbiter_if #(.AW(AW), .DW(DW)) u_if1 ();
    shared_mem_arbiter_if #(.AW(AW), .DW(DW)) u_if2 ();

    shared_mem_arbiter #(.AW(AW), .DW(DW), .LAT(2))  u_dut0 (.clk_i(clk), .rst_i(rst_n), .bus(u_if0.slave));
    shared_mem_arbiter #(.AW(AW), .DW(DW), .LAT(1))  u_dut1 (.clk_i(clk), .rst_i(rst_n), .bus(u_if1.slave));
    shared_mem_arbiter #(.AW(AW), .DW(DW), .LAT(15)) u_dut2 (.clk_i(clk), .rst_i(rst_n), .bus(u_if2.slave));

    assign u_if0.if_req_i    = (sel == 0) & t_if_req;
    assign u_if0.if_addr_i   = t_if_addr;
    assign u_if0.mem_read_i  = (sel == 0) & t_mem_read;
    assign u_if0.mem_write_i = (sel == 0) & t_mem_write;
    assign u_if0.mem_addr_i  = t_mem_addr;
    assign u_if0.mem_wdata_i = t_mem_wdata;
    assign u_if0.ram_rdata_i = ram_rdata;
    assign u_if1.if_req_i    = (sel == 1) & t_if_req;
    assign u_if1.if_addr_i   = t_if_addr;
    assign u_if1.mem_read_i  = (sel == 1) & t_mem_read;
    assign u_if1.mem_write_i = (sel == 1) & t_mem_write;
    assign u_if1.mem_addr_i  = t_mem_addr;
    assign u_if1.mem_wdata_i = t_mem_wdata;
    assign u_if1.ram_rdata_i = ram_rdata;
    assign u_if2.if_req_i    = (sel == 2) & t_if_req;
    assign u_if2.if_addr_i   = t_if_addr;
    assign u_if2.mem_read_i  = (sel == 2) & t_mem_read;
    assign u_if2.mem_write_i = (sel == 2) & t_mem_write;
    assign u_if2.mem_addr_i  = t_mem_addr;
    assign u_if2.mem_wdata_i = t_mem_wdata;
    assign u_if2.ram_rdata_i = ram_rdata;

    // Observe the selected instance
    always_comb begin
        cur_lat     = 2;
        o_if_stall  = u_if0.if_stall_o;  o_mem_stall = u_if0.mem_stall_o;
        o_if_rdata  = u_if0.if_rdata_o;  o_mem_rdata = u_if0.mem_rdata_o;
        o_ram_en    = u_if0.ram_en_o;    o_ram_we    = u_if0.ram_we_o;
        o_ram_addr  = u_if0.ram_addr_o;  o_ram_wdata = u_if0.ram_wdata_o;
        if (sel == 1) begin
            cur_lat     = 1;
            o_if_stall  = u_if1.if_stall_o;  o_mem_stall = u_if1.mem_stall_o;
            o_if_rdata  = u_if1.if_rdata_o;  o_mem_rdata = u_if1.mem_rdata_o;
            o_ram_en    = u_if1.ram_en_o;    o_ram_we    = u_if1.ram_we_o;
            o_ram_addr  = u_if1.ram_addr_o;  o_ram_wdata = u_if1.ram_wdata_o;
        end else if (sel == 2) begin
            cur_lat     = 15;
            o_if_stall  = u_if2.if_stall_o;  o_mem_stall = u_if2.mem_stall_o;
            o_if_rdata  = u_if2.if_rdata_o;  o_mem_rdata = u_if2.mem_rdata_o;
            o_ram_en    = u_if2.ram_en_o;    o_ram_we    = u_if2.ram_we_o;
            o_ram_addr  = u_if2.ram_addr_o;  o_ram_wdata = u_if2.ram_wdata_o;
        end
    end

    // ---------------- RAM model --------------------------------------------
    // Read data is valid only in the LAT-th cycle of ram_en. Garbage otherwise.
    // Writes commit in that same cycle.
    logic [31:0] ram [0:31];
    int          en_run = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hA500_0000 + 32'(i));
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 32; i++) ram[i] <= init_word(i);
        end else if (o_ram_en && o_ram_we && en_run == cur_lat - 1) begin
            ram[o_ram_addr[6:2]] <= o_ram_wdata;
        end
        en_run <= o_ram_en ? en_run + 1 : 0;
    end

    always_comb begin
        ram_rdata = 32'hBAD0_0000 | 32'(en_run);
        if (o_ram_en && en_run == cur_lat - 1) ram_rdata = ram[o_ram_addr[6:2]];
    end

    // ---------------- checking helpers -------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        int          s;          // instance: 0 LAT2, 1 LAT1, 2 LAT15
        int          op;         // 0 fetch, 1 load, 2 store
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_stall;  // cycles with stall high
        logic [31:0] exp_rd;
    } vec_t;

    task automatic drop_all();
        t_if_req = 1'b0; t_mem_read = 1'b0; t_mem_write = 1'b0;
    endtask

    // One access from IDLE. Measures stall, enable and write-enable lengths.
    // Entered and left at posedge+1.
    task automatic do_access(input string nm, input vec_t v);
        int stalls = 0, ens = 0, wes = 0;
        logic [31:0] rd = '0;
        logic addr_ok = 1'b1, wd_ok = 1'b1, done = 1'b0;
        sel = v.s;
        case (v.op)
            0: begin t_if_req = 1'b1; t_if_addr = v.addr; end
            1: begin t_mem_read = 1'b1; t_mem_addr = v.addr; end
            default: begin t_mem_write = 1'b1; t_mem_addr = v.addr; t_mem_wdata = v.wdata; end
        endcase
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (o_ram_en) begin
                ens++;
                if (o_ram_addr !== v.addr) addr_ok = 1'b0;
            end
            if (o_ram_we) begin
                wes++;
                if (o_ram_wdata !== v.wdata) wd_ok = 1'b0;
            end
            if ((v.op == 0) ? o_if_stall : o_mem_stall) stalls++;
            else begin
                done = 1'b1;
                rd = (v.op == 0) ? o_if_rdata : o_mem_rdata;
            end
            @(posedge clk); #1;
        end
        drop_all();
        check({nm, "_done"},   32'(done), 32'd1);
        check({nm, "_stall"},  32'(stalls), 32'(v.exp_stall));
        check({nm, "_en_len"}, 32'(ens), 32'(v.exp_stall - 1));
        check({nm, "_we_len"}, 32'(wes), (v.op == 2) ? 32'(v.exp_stall - 1) : 32'd0);
        check({nm, "_addr"},   32'(addr_ok), 32'd1);
        if (v.op == 2) check({nm, "_wdata"}, 32'(wd_ok), 32'd1);
        else           check({nm, "_rdata"}, rd, v.exp_rd);
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 31)) << 2;
    endfunction

    // Randomized traffic against a transaction-level reference.
    // The reference keeps three facts: whether the RAM is occupied, the cycle
    // of the grant, and the request latched then. An access granted at cycle
    // g enables the RAM for cycles g+1..g+L. It releases the owner's stall at
    // g+L+1, and the next grant is possible at g+L+2.
    task automatic run_random(input int s, input int ncyc);
        int          lat = (s == 0) ? 2 : (s == 1) ? 1 : 15;
        logic [31:0] mmem [0:31];
        logic        busy = 1'b0, own_data = 1'b0, m_we = 1'b0;
        int          start = 0;
        logic [31:0] m_addr = '0, e_if_rd = '0, e_mem_rd = '0;
        logic        in_done, e_if_stall, e_mem_stall, e_en;
        logic        if_done = 1'b0, mem_done = 1'b0;
        int          op;
        for (int i = 0; i < 32; i++) mmem[i] = init_word(i);
        sel = s;
        drop_all();
        rst_n = 1'b0; ram_init = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; ram_init = 1'b0;
        for (int t = 0; t < ncyc; t++) begin
            // Pipeline-side behaviour: hold a request until served.
            // Occasionally flush it or change the address under it.
            if (if_done || !t_if_req) begin
                t_if_req  = ($urandom_range(0, 2) != 0);
                t_if_addr = rnd_addr();
            end else if ($urandom_range(0, 15) == 0) t_if_req = 1'b0;
            else if ($urandom_range(0, 7) == 0) t_if_addr = rnd_addr();
            if (mem_done || !(t_mem_read || t_mem_write)) begin
                op = int'($urandom_range(0, 9));
                t_mem_read  = (op >= 3 && op <= 6) || op == 9;
                t_mem_write = (op >= 7);
                t_mem_addr  = rnd_addr();
                t_mem_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                t_mem_read = 1'b0; t_mem_write = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                t_mem_addr = rnd_addr(); t_mem_wdata = $urandom;
            end

            if (busy && t >= start + lat + 2) busy = 1'b0;
            in_done = busy && (t == start + lat + 1);
            if (in_done && !own_data) e_if_rd = mmem[m_addr[6:2]];
            if (in_done && own_data && !m_we) e_mem_rd = mmem[m_addr[6:2]];
            e_if_stall  = t_if_req && !(in_done && !own_data);
            e_mem_stall = (t_mem_read || t_mem_write) && !(in_done && own_data);
            e_en        = busy && t > start && t <= start + lat;

            @(negedge clk);
            check("rnd_if_stall",  32'(o_if_stall),  32'(e_if_stall));
            check("rnd_mem_stall", 32'(o_mem_stall), 32'(e_mem_stall));
            check("rnd_ram_en",    32'(o_ram_en),    32'(e_en));
            check("rnd_if_rdata",  o_if_rdata,  e_if_rd);
            check("rnd_mem_rdata", o_mem_rdata, e_mem_rd);
            if (e_en) begin
                check("rnd_ram_addr", o_ram_addr, m_addr);
                check("rnd_ram_we",   32'(o_ram_we), 32'(m_we));
            end

            if (!busy && (t_mem_read || t_mem_write)) begin
                busy = 1'b1; start = t; own_data = 1'b1;
                m_we = t_mem_write; m_addr = t_mem_addr;
                if (m_we) mmem[m_addr[6:2]] = t_mem_wdata;
            end else if (!busy && t_if_req) begin
                busy = 1'b1; start = t; own_data = 1'b0;
                m_we = 1'b0; m_addr = t_if_addr;
            end
            if_done  = t_if_req && !e_if_stall;
            mem_done = (t_mem_read || t_mem_write) && !e_mem_stall;
            @(posedge clk); #1;
        end
        drop_all();
        repeat (20) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence -----------------------------------------
    vec_t        vecs [9];
    int          mem_done_c, if_done_c;
    logic [31:0] a_c1, a_c5, mrd, ird;

    initial begin
        vecs[0] = '{0, 0, 32'h10, 32'h0,        3,  32'hDEADBEEF};
        vecs[1] = '{0, 2, 32'h40, 32'h00001234, 3,  32'h0};
        vecs[2] = '{0, 1, 32'h40, 32'h0,        3,  32'h00001234};
        vecs[3] = '{1, 0, 32'h10, 32'h0,        2,  32'hDEADBEEF};
        vecs[4] = '{1, 2, 32'h44, 32'hCAFE0001, 2,  32'h0};
        vecs[5] = '{1, 1, 32'h44, 32'h0,        2,  32'hCAFE0001};
        vecs[6] = '{2, 0, 32'h14, 32'h0,        16, 32'hA5000005};
        vecs[7] = '{2, 2, 32'h48, 32'h0BADF00D, 16, 32'h0};
        vecs[8] = '{2, 1, 32'h48, 32'h0,        16, 32'h0BADF00D};

        sel = 0; rst_n = 1'b0; ram_init = 1'b1;
        t_if_req = 1'b1; t_if_addr = 32'h10;
        t_mem_read = 1'b0; t_mem_write = 1'b0; t_mem_addr = '0; t_mem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_en",    32'(o_ram_en), 32'd0);
        check("rst_ram_we",    32'(o_ram_we), 32'd0);
        check("rst_ram_addr",  o_ram_addr,  32'd0);
        check("rst_ram_wdata", o_ram_wdata, 32'd0);
        check("rst_if_rdata",  o_if_rdata,  32'd0);
        check("rst_mem_rdata", o_mem_rdata, 32'd0);
        check("rst_if_stall",  32'(o_if_stall),  32'd1);
        check("rst_mem_stall", 32'(o_mem_stall), 32'd0);
        @(posedge clk); #1;
        drop_all();
        rst_n = 1'b1; ram_init = 1'b0;

        for (int i = 0; i < 9; i++) do_access($sformatf("vec%0d", i), vecs[i]);

        // Load and fetch raised together: the load goes first.
        sel = 0; mem_done_c = -1; if_done_c = -1; a_c1 = '0; a_c5 = '0; mrd = '0; ird = '0;
        t_mem_read = 1'b1; t_mem_addr = 32'h40; t_if_req = 1'b1; t_if_addr = 32'h10;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 1) a_c1 = o_ram_addr;
            if (c == 5) a_c5 = o_ram_addr;
            if (t_mem_read && !o_mem_stall && mem_done_c < 0) begin mem_done_c = c; mrd = o_mem_rdata; end
            if (t_if_req && !o_if_stall && if_done_c < 0) begin if_done_c = c; ird = o_if_rdata; end
            @(posedge clk); #1;
            if (mem_done_c >= 0) t_mem_read = 1'b0;
            if (if_done_c >= 0) t_if_req = 1'b0;
            if (mem_done_c >= 0 && if_done_c >= 0) break;
        end
        drop_all();
        check("prio_mem_done_cycle", 32'(mem_done_c), 32'd3);
        check("prio_if_done_cycle",  32'(if_done_c),  32'd7);
        check("prio_first_addr",     a_c1, 32'h40);
        check("prio_second_addr",    a_c5, 32'h10);
        check("prio_load_data",      mrd,  32'h00001234);
        check("prio_fetch_data",     ird,  32'hDEADBEEF);

        // Fetch flushed during BUSY: no stall, data still captured.
        t_if_req = 1'b1; t_if_addr = 32'h14;
        @(negedge clk);
        check("flush_req_stall", 32'(o_if_stall), 32'd1);
        @(posedge clk); #1;
        t_if_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("flush_stall_c%0d", k), 32'(o_if_stall), 32'd0);
        end
        check("flush_rdata", o_if_rdata, 32'hA5000005);
        @(posedge clk); #1;
        do_access("flush_next", '{0, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF});

        // Reset in the middle of BUSY.
        t_if_req = 1'b1; t_if_addr = 32'h14;
        @(posedge clk); #1;
        check("rstmid_en_before", 32'(o_ram_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_en_after", 32'(o_ram_en), 32'd0);
        check("rstmid_addr",     o_ram_addr, 32'd0);
        check("rstmid_rdata",    o_if_rdata, 32'd0);
        check("rstmid_stall",    32'(o_if_stall), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_access("rstmid_next", '{0, 0, 32'h14, 32'h0, 3, 32'hA5000005});

        run_random(0, 500);
        run_random(1, 400);
        run_random(2, 800);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
